// File: rtl/fetch_predecode_stage_pkg.sv
// Shared definitions for the fetch/predecode stage: RV32I major opcodes,
// one-hot instruction-type constants (also used by the immediate generator) and FSM states.
package fetch_predecode_stage_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [5:0] INST_R = 6'b100000;
  localparam logic [5:0] INST_I = 6'b010000;
  localparam logic [5:0] INST_S = 6'b001000;
  localparam logic [5:0] INST_B = 6'b000100;
  localparam logic [5:0] INST_U = 6'b000010;
  localparam logic [5:0] INST_J = 6'b000001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DRAIN,
    ST_HOLD
  } fetch_state_e;

endpackage

// File: rtl/fetch_predecode_stage_opcode_predecoder.sv
// Combinational opcode classifier: maps instruction[6:0] to a one-hot format type.
// Unknown opcodes report R format (zero immediate) and raise illegal.
module opcode_predecoder
  import fetch_predecode_stage_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [5:0] inst_type,
  output logic       illegal
);

  always_comb begin
    inst_type = INST_R;
    illegal   = 1'b0;
    case (opcode)
      OPC_OP:                                     inst_type = INST_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: inst_type = INST_I;
      OPC_STORE:                                  inst_type = INST_S;
      OPC_BRANCH:                                 inst_type = INST_B;
      OPC_LUI, OPC_AUIPC:                         inst_type = INST_U;
      OPC_JAL:                                    inst_type = INST_J;
      default: begin
        inst_type = INST_R;
        illegal   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fetch_predecode_stage.sv
// Instruction fetch stage: owns the PC, keeps at most one request outstanding,
// and holds the predecoded word in the IF/ID register until decode takes it.
module fetch_predecode_stage
  import fetch_predecode_stage_pkg::*;
#(
  parameter int             LEN      = 32,
  parameter logic [LEN-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           imem_req_valid,
  input  logic           imem_req_ready,
  output logic [LEN-1:0] imem_addr,
  input  logic           imem_resp_valid,
  input  logic [LEN-1:0] imem_resp_data,
  input  logic           redirect_valid,
  input  logic [LEN-1:0] redirect_pc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [LEN-1:0] out_pc,
  output logic [LEN-1:0] out_instruction,
  output logic [5:0]     out_inst_type,
  output logic           out_illegal
);

  fetch_state_e   state;
  logic [LEN-1:0] pc;
  logic [5:0]     pd_type;
  logic           pd_illegal;

  opcode_predecoder u_predecoder (
    .opcode    (imem_resp_data[6:0]),
    .inst_type (pd_type),
    .illegal   (pd_illegal)
  );

  // A pending redirect suppresses the request so a stale address is never accepted.
  assign imem_req_valid = (state == ST_FETCH) && !redirect_valid;
  assign imem_addr      = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      pc              <= RESET_PC;
      out_valid       <= 1'b0;
      out_pc          <= '0;
      out_instruction <= '0;
      out_inst_type   <= INST_R;
      out_illegal     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_FETCH;

        ST_FETCH: begin
          if (redirect_valid) pc <= redirect_pc;
          else if (imem_req_ready) state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= imem_resp_valid ? ST_FETCH : ST_DRAIN;
          end else if (imem_resp_valid) begin
            out_valid       <= 1'b1;
            out_pc          <= pc;
            out_instruction <= imem_resp_data;
            out_inst_type   <= pd_type;
            out_illegal     <= pd_illegal;
            pc              <= pc + LEN'(4);
            state           <= ST_HOLD;
          end
        end

        // The request already in flight must be absorbed before a new one is issued.
        ST_DRAIN: begin
          if (redirect_valid) pc <= redirect_pc;
          if (imem_resp_valid) state <= ST_FETCH;
        end

        ST_HOLD: begin
          if (redirect_valid) begin
            out_valid <= 1'b0;
            pc        <= redirect_pc;
            state     <= ST_FETCH;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_FETCH;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_predecode_stage.sv
// Self-checking bench for fetch_predecode_stage: table-driven fetches with a
// scoreboard of expected IF/ID contents, plus hand sequences for stall/redirect/reset.
module tb_fetch_predecode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
  logic [5:0]  out_inst_type;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int          lat;
    logic [5:0]  typ;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  typ;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[12];
  logic [31:0] exp_pc;

  fetch_predecode_stage #(.LEN(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instruction (out_instruction),
    .out_inst_type   (out_inst_type),
    .out_illegal     (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    repeat (2) tick();
    rst_n  = 1'b1;
    exp_pc = 32'h0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) checkOutput("req_timeout", 32'd0, 32'd1);
  endtask

  // One complete fetch: request handshake at exp_pc, response after lat cycles.
  task automatic applyStimulus(input logic [31:0] data, input int lat, input logic [5:0] typ, input logic ill);
    bit ok;
    exp_t e;
    wait_req(ok);
    if (!ok) return;
    checkOutput("imem_addr", imem_addr, exp_pc);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    repeat (lat - 1) tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    e.pc = exp_pc; e.instr = data; e.typ = typ; e.ill = ill;
    sb.push_back(e);
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'hDEAD_BEEF;
    exp_pc = exp_pc + 32'd4;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("out_pc", out_pc, e.pc);
        checkOutput("out_instruction", out_instruction, e.instr);
        checkOutput("out_inst_type", {26'd0, out_inst_type}, {26'd0, e.typ});
        checkOutput("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
        checkOutput("onehot", {31'd0, $onehot(out_inst_type)}, 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    logic [31:0] held_pc, held_instr;

    vecs[0]  = '{32'h0000_0463, 1, 6'b000100, 1'b0};
    vecs[1]  = '{32'h0080_00EF, 1, 6'b000001, 1'b0};
    vecs[2]  = '{32'h0000_0033, 2, 6'b100000, 1'b0};
    vecs[3]  = '{32'h0000_2003, 3, 6'b010000, 1'b0};
    vecs[4]  = '{32'h0000_2023, 1, 6'b001000, 1'b0};
    vecs[5]  = '{32'h0000_00B7, 2, 6'b000010, 1'b0};
    vecs[6]  = '{32'h0000_0097, 1, 6'b000010, 1'b0};
    vecs[7]  = '{32'h0000_0067, 1, 6'b010000, 1'b0};
    vecs[8]  = '{32'h0000_0073, 4, 6'b010000, 1'b0};
    vecs[9]  = '{32'h0000_007F, 1, 6'b100000, 1'b1};
    vecs[10] = '{32'h0000_0000, 2, 6'b100000, 1'b1};
    vecs[11] = '{32'h00A0_0013, 1, 6'b010000, 1'b0};

    out_ready = 1'b1;
    do_reset();

    // Reset values, then first fetch with one-cycle memory latency.
    checkOutput("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    checkOutput("rst_out_pc", out_pc, 32'd0);
    checkOutput("rst_out_instruction", out_instruction, 32'd0);
    checkOutput("rst_out_inst_type", {26'd0, out_inst_type}, 32'h20);
    tick();
    checkOutput("c1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    applyStimulus(32'h0050_0093, 1, 6'b010000, 1'b0);
    checkOutput("c3_out_valid", {31'd0, out_valid}, 32'd1);
    tick();

    // Table of back-to-back fetches.
    do_reset();
    foreach (vecs[i]) applyStimulus(vecs[i].data, vecs[i].lat, vecs[i].typ, vecs[i].ill);
    tick();

    // Decode stall: IF/ID must hold and no new request may issue.
    do_reset();
    out_ready = 1'b0;
    applyStimulus(32'h0050_0093, 2, 6'b010000, 1'b0);
    held_pc = 32'h0; held_instr = 32'h0050_0093;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stall_out_pc", out_pc, held_pc);
      checkOutput("stall_out_instruction", out_instruction, held_instr);
      checkOutput("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    applyStimulus(32'h0000_0033, 1, 6'b100000, 1'b0);
    tick();

    // Redirect while waiting; late response must be dropped.
    wait_req(ok);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    checkOutput("drain_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0033;
    tick();
    imem_resp_valid = 1'b0;
    checkOutput("drop_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("redir_addr", imem_addr, 32'h100);

    // Redirect and response in the same WAIT cycle.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h200;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_006F;
    tick();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    checkOutput("same_cycle_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("same_cycle_addr", imem_addr, 32'h200);

    // Redirect during FETCH must block the handshake.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    imem_req_ready = 1'b1;
    #1;
    checkOutput("fetch_redir_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    exp_pc = 32'h300;
    applyStimulus(32'h0000_0463, 1, 6'b000100, 1'b0);
    tick();

    // Illegal opcode, then async reset asserted mid-WAIT.
    applyStimulus(32'h0000_007F, 1, 6'b100000, 1'b1);
    tick();
    wait_req(ok);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("arst_out_illegal", {31'd0, out_illegal}, 32'd0);
    checkOutput("arst_out_pc", out_pc, 32'd0);
    checkOutput("arst_out_instruction", out_instruction, 32'd0);
    checkOutput("arst_out_inst_type", {26'd0, out_inst_type}, 32'h20);
    checkOutput("arst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0033;
    tick();
    tick();
    imem_resp_valid = 1'b0;
    checkOutput("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("post_rst_addr", imem_addr, 32'h0);

    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
